// File: rtl/bram_client_pkg.sv
// Shared elaboration helpers for the single-port BRAM client: read latency
// and occupancy-counter width.
package bram_client_pkg;

    localparam int DEFAULT_RESP_DEPTH = 4;
    localparam int DEFAULT_OCC_WIDTH  = $clog2(DEFAULT_RESP_DEPTH + 1);

    // Cycles from the BRAM address edge to the edge where read data can be captured.
    function automatic int calc_lat(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    // Width that holds 0..depth inclusive.
    function automatic int calc_occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Response buffer for the BRAM client: synchronous FIFO with combinational
// head data and simultaneous push/pop allowed even when full.
module bram_resp_fifo
    import bram_client_pkg::*;
#(
    parameter int RESP_DEPTH = DEFAULT_RESP_DEPTH,
    parameter int DATA_WIDTH = 512
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                push,
    input  logic [DATA_WIDTH-1:0]               push_data,
    input  logic                                pop,
    output logic [DATA_WIDTH-1:0]               pop_data,
    output logic                                full,
    output logic                                empty,
    output logic [$clog2(RESP_DEPTH+1)-1:0]     count
);

    localparam int CNT_W = calc_occ_width(RESP_DEPTH);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are exactly PTR_W bits over a power-of-two depth, so they wrap on their own.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; validity lives in the pointers and count.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(RESP_DEPTH));
    assign empty    = (count == '0);

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(push && full && !pop));

endmodule

// File: rtl/bram1_client.sv
// Request/response adapter in front of one single-ported synchronous BRAM;
// credit-based flow control keeps the response FIFO from overflowing.
module bram1_client
    import bram_client_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 512,
    parameter int PIPELINED  = 1,
    parameter int RESP_DEPTH = DEFAULT_RESP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT   = calc_lat(PIPELINED);
    localparam int OCC_W = calc_occ_width(RESP_DEPTH);

    logic             fire;
    logic             issue_rd;
    logic [LAT-1:0]   rd_sr;
    logic             ready_q;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] fifo_count;
    logic [OCC_W-1:0] occ;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign fire      = req_valid && req_ready;
    assign issue_rd  = fire && !req_write;

    assign bram_en   = fire;
    assign bram_we   = fire && req_write;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

    // rd_sr[LAT-1] marks the edge where bram_do holds the data for a read issued LAT edges earlier.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_sr   <= '0;
            ready_q <= 1'b0;
        end else begin
            rd_sr   <= LAT'({rd_sr, issue_rd});
            ready_q <= 1'b1;
        end
    end

    // NOTE: combinational logic gets a default first and uses blocking assignments, so no latch is inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + OCC_W'(rd_sr[i]);
        end
    end

    assign occ       = inflight + fifo_count;
    assign req_ready = ready_q && (occ < OCC_W'(RESP_DEPTH));

    assign fifo_push  = rd_sr[LAT-1];
    assign fifo_pop   = resp_valid && resp_ready;
    assign resp_valid = !fifo_empty;

    bram_resp_fifo #(
        .RESP_DEPTH (RESP_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (fifo_push),
        .push_data (bram_do),
        .pop       (fifo_pop),
        .pop_data  (resp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_push_has_room: assert property (@(posedge CLK) disable iff (!RST_N)
        !(fifo_push && fifo_full && !fifo_pop));
    a_occ_bound: assert property (@(posedge CLK) disable iff (!RST_N)
        occ <= OCC_W'(RESP_DEPTH));

endmodule

// File: tb/tb_bram1_client.sv
// Directed and randomized bench for bram1_client: two instances (pipelined and
// non-pipelined BRAM) each with a behavioural BRAM model.
`timescale 1ns/1ps
module tb_bram1_client;

    localparam int AW = 7;
    localparam int DW = 512;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A: PIPELINED = 1
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di, bram_do;

    // Instance B: PIPELINED = 0
    logic          np_req_valid, np_req_ready, np_req_write;
    logic [AW-1:0] np_req_addr;
    logic [DW-1:0] np_req_data;
    logic          np_resp_valid, np_resp_ready;
    logic [DW-1:0] np_resp_data;
    logic          np_bram_en, np_bram_we;
    logic [AW-1:0] np_bram_addr;
    logic [DW-1:0] np_bram_di, np_bram_do;

    bram1_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1), .RESP_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_di(bram_di), .bram_do(bram_do)
    );

    bram1_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0), .RESP_DEPTH(4)) dut_np (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(np_req_valid), .req_ready(np_req_ready), .req_write(np_req_write),
        .req_addr(np_req_addr), .req_data(np_req_data),
        .resp_valid(np_resp_valid), .resp_ready(np_resp_ready), .resp_data(np_resp_data),
        .bram_en(np_bram_en), .bram_we(np_bram_we), .bram_addr(np_bram_addr),
        .bram_di(np_bram_di), .bram_do(np_bram_do)
    );

    // BRAM models: A has array read plus output register, B has array read only.
    logic [DW-1:0] mem_a [2**AW];
    logic [DW-1:0] mem_b [2**AW];
    logic [DW-1:0] rd_a, out_a, rd_b;

    always @(posedge CLK) begin
        if (bram_en) begin
            if (bram_we) mem_a[bram_addr] <= bram_di;
            else         rd_a <= mem_a[bram_addr];
        end
        out_a <= rd_a;
    end
    assign bram_do = out_a;

    always @(posedge CLK) begin
        if (np_bram_en) begin
            if (np_bram_we) mem_b[np_bram_addr] <= np_bram_di;
            else            rd_b <= mem_b[np_bram_addr];
        end
    end
    assign np_bram_do = rd_b;

    // Response collector and reference memory
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            got_cyc[$];
    int            cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (RST_N && resp_valid && resp_ready) begin
            got_q.push_back(resp_data);
            got_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int unsigned s);
        logic [31:0] w;
        w = s * 32'h9E37_79B1 + 32'h0000_1234;
        return {16{w}};
    endfunction

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && waited < 40) begin
            tick();
            waited++;
        end
        if (!req_ready) begin
            check("issue_timeout", req_ready, 1);
        end else begin
            if (wr) ref_mem[a] = d;
            tick();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a5;
        int n;
        int stalls;
        int seen;
        a5 = {64{8'hA5}};
        foreach (mem_a[i]) begin
            mem_a[i]   = '0;
            mem_b[i]   = '0;
            ref_mem[i] = '0;
        end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5; req_data = a5; resp_ready = 1'b1;
        np_req_valid = 1'b0; np_req_write = 1'b0; np_req_addr = '0; np_req_data = '0;
        np_resp_ready = 1'b1;

        // Reset: request held valid must not reach the BRAM.
        repeat (3) @(posedge CLK);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_occ", dut.occ, 0);
        req_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("ready_before_first_edge", req_ready, 0);
        tick();
        check("ready_after_first_edge", req_ready, 1);

        // Write addr 5 then read it back; BRAM strobes are combinational.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5; req_data = a5;
        #1;
        check("wr_bram_en", bram_en, 1);
        check("wr_bram_we", bram_we, 1);
        check("wr_bram_addr", bram_addr, 5);
        check("wr_bram_di", bram_di, a5);
        tick();
        ref_mem[5] = a5;
        req_write = 1'b0; req_data = '0;
        #1;
        check("rd_bram_en", bram_en, 1);
        check("rd_bram_we", bram_we, 0);
        got_q.delete();
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin
            tick();
            n++;
        end
        check("lat_pipelined", n, 3);
        check("rd_after_wr_data", resp_data, a5);
        repeat (4) tick();
        check("single_response", got_q.size(), 1);
        check("resp_valid_idle", resp_valid, 0);

        // Same scenario on the non-pipelined instance.
        np_req_valid = 1'b1; np_req_write = 1'b1; np_req_addr = 5; np_req_data = a5;
        check("np_ready", np_req_ready, 1);
        tick();
        np_req_write = 1'b0;
        tick();
        np_req_valid = 1'b0;
        n = 1;
        while (!np_resp_valid && n < 10) begin
            tick();
            n++;
        end
        check("lat_nonpipelined", n, 2);
        check("np_rd_data", np_resp_data, a5);
        repeat (3) tick();
        check("np_resp_valid_idle", np_resp_valid, 0);

        // Fill with resp_ready low, then pop/issue in the same cycle.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), pat(10 + i));
        resp_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), '0);
        check("occ_after_4_reads", dut.occ, 4);
        check("ready_low_after_4", req_ready, 0);
        repeat (4) tick();
        check("occ_fifo_full", dut.occ, 4);
        check("full_resp_valid", resp_valid, 1);
        check("full_head_data", resp_data, pat(10));
        tick();
        check("head_data_stable", resp_data, pat(10));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("occ_after_pop", dut.occ, 3);
        check("ready_before_issue_pop", req_ready, 1);
        resp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 0;
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        check("occ_issue_and_pop", dut.occ, 3);
        issue(1'b0, 1, '0);
        check("occ_refilled", dut.occ, 4);
        check("ready_low_refilled", req_ready, 0);
        repeat (4) tick();
        check("occ_full_again", dut.occ, 4);
        resp_ready = 1'b1;
        repeat (12) tick();
        check("order_count", got_q.size(), 6);
        exp_q = '{pat(10), pat(11), pat(12), pat(13), pat(10), pat(11)};
        for (int i = 0; i < 6; i++)
            check($sformatf("order_%0d", i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        check("ready_reasserts", req_ready, 1);
        check("occ_drained", dut.occ, 0);

        // 64 back-to-back reads.
        for (int i = 0; i < 64; i++) issue(1'b1, AW'(i), pat(100 + i));
        got_q.delete(); got_cyc.delete();
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            if (!req_ready) stalls++;
            issue(1'b0, AW'(i), '0);
        end
        n = 0;
        while (got_q.size() < 64 && n < 20) begin
            tick();
            n++;
        end
        check("b2b_stalls", stalls, 0);
        check("b2b_count", got_q.size(), 64);
        for (int i = 0; i < 64; i++)
            check($sformatf("b2b_data_%0d", i), (i < got_q.size()) ? got_q[i] : 'x, pat(100 + i));
        if (got_cyc.size() == 64) check("b2b_one_per_cycle", got_cyc[63] - got_cyc[0], 63);

        // Reset with two reads in flight.
        issue(1'b1, 10, pat(200));
        issue(1'b1, 11, pat(201));
        issue(1'b1, 12, pat(202));
        resp_ready = 1'b0;
        got_q.delete();
        issue(1'b0, 10, '0);
        issue(1'b0, 11, '0);
        tick();
        RST_N = 1'b0;
        #1;
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_occ", dut.occ, 0);
        check("midrst_ready", req_ready, 0);
        tick();
        RST_N = 1'b1;
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        check("no_stale_valid", seen, 0);
        check("no_stale_collected", got_q.size(), 0);
        issue(1'b0, 12, '0);
        n = 0;
        while (got_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        check("post_rst_count", got_q.size(), 1);
        check("post_rst_data", (got_q.size() > 0) ? got_q[0] : 'x, pat(202));

        // Random valid/ready traffic against the reference memory.
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic fire;
            if (!req_valid && $urandom_range(0, 3) != 0) begin
                req_valid = 1'b1;
                req_write = ($urandom_range(0, 2) == 0);
                req_addr  = AW'($urandom_range(0, 15));
                req_data  = pat($urandom());
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            fire = req_valid && req_ready;
            if (fire) begin
                if (req_write) ref_mem[req_addr] = req_data;
                else           exp_q.push_back(ref_mem[req_addr]);
            end
            tick();
            if (fire) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        while ((got_q.size() != exp_q.size() || dut.occ != 0) && n < 40) begin
            tick();
            n++;
        end
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_data_%0d", i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bram1_client.md
BRAM1_CLIENT -- requirements
Module: bram1_client

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 7, BRAM address width; DATA_WIDTH, default 512, word width; PIPELINED, default 1, matches the attached BRAM output register mode; RESP_DEPTH, default 4, response FIFO entries (power of 2, minimum 2).
REQ-002 Clock and reset SHALL be: CLK, in, 1, single clock, rising edge; RST_N, in, 1, asynchronous active-low reset.
REQ-003 The request ports SHALL be: req_valid in 1; req_ready out 1; req_write in 1 (1 = write, 0 = read); req_addr in ADDR_WIDTH; req_data in DATA_WIDTH (write data).
REQ-004 The response ports SHALL be: resp_valid out 1; resp_ready in 1; resp_data out DATA_WIDTH (read data).
REQ-005 The BRAM-side ports SHALL be: bram_en out 1; bram_we out 1; bram_addr out ADDR_WIDTH; bram_di out DATA_WIDTH; bram_do in DATA_WIDTH. They connect directly to a single-ported synchronous BRAM.

Function
REQ-006 LAT SHALL be 2 when PIPELINED is nonzero and 1 otherwise.
REQ-007 A request SHALL be accepted (fire) on any rising edge where req_valid and req_ready are both 1.
REQ-008 Requester signals SHALL be held stable while req_valid=1 and req_ready=0.
REQ-009 bram_en SHALL equal fire, and bram_we SHALL equal fire AND req_write. Both are combinational.
REQ-010 bram_addr SHALL equal req_addr and bram_di SHALL equal req_data, combinationally. They are don't-care when bram_en=0.
REQ-011 A write SHALL produce no response.
REQ-012 A read SHALL produce exactly one response.
REQ-013 Responses SHALL be returned in issue order.
REQ-014 A read-issue shift register, LAT bits, SHALL shift in (fire AND NOT req_write) every cycle.
REQ-015 When the oldest bit of the read-issue shift register is 1, bram_do SHALL be pushed into the response FIFO at that edge. That edge is exactly LAT cycles after the issue edge.
REQ-016 resp_valid SHALL assert in the cycle after the push. Read issue to resp_valid SHALL be LAT+1 cycles when the FIFO is empty.
REQ-017 occ SHALL equal the number of set bits in the read-issue shift register plus the FIFO count. Its width SHALL be clog2(RESP_DEPTH+1).
REQ-018 req_ready SHALL be 1 iff occ < RESP_DEPTH. req_ready SHALL be registered-derived and SHALL NOT depend on req_valid, req_write or resp_ready.
REQ-019 Writes SHALL also be blocked when req_ready=0. This keeps a single ready rule.
REQ-020 A FIFO pop SHALL occur when resp_valid AND resp_ready.
REQ-021 A simultaneous push and pop SHALL leave the FIFO count unchanged, including when the FIFO is full.
REQ-022 A simultaneous issue and pop SHALL leave occ unchanged.
REQ-023 Credit accounting SHALL guarantee that the FIFO never overflows. Push-when-full is an assertion failure.
REQ-024 FIFO read and write pointers SHALL wrap modulo RESP_DEPTH.
REQ-025 resp_data SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-026 Back-to-back reads SHALL sustain one issue per cycle when resp_ready is held at 1.
REQ-027 A read following a write to the same address SHALL return the new data. Ordering is provided by the single BRAM port.

Reset
REQ-028 While RST_N=0, the block SHALL hold: resp_valid=0, req_ready=0, bram_en=0, bram_we=0, read-issue shift register=0, FIFO pointers and count=0, occ=0.
REQ-029 req_ready SHALL become 1 on the first rising edge after RST_N deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight reads and buffered responses. No stale response SHALL ever appear after reset.
REQ-031 BRAM contents SHALL NOT be affected by reset.
REQ-032 The FIFO data storage SHALL NOT be reset.

Structure
REQ-033 A shared package bram_client_pkg SHALL hold the LAT computation (function of PIPELINED) and the occ-width localparam.
REQ-034 One sub-module, bram_resp_fifo, SHALL be used: a synchronous FIFO with RESP_DEPTH and DATA_WIDTH parameters, push/pop/full/empty/count outputs, and the same CLK/RST_N.

Verification
REQ-035 Bench scenario: write addr 5 = 0xA5…A5, then read addr 5 -> one response, resp_data=0xA5…A5, resp_valid 3 cycles after the read fire with PIPELINED=1 and 2 cycles with PIPELINED=0.
REQ-036 Bench scenario: resp_ready=0, issue 4 reads to addrs 0–3 -> req_ready=0 after the 4th fire; raise resp_ready -> data returned in order 0,1,2,3 and req_ready reasserts.
REQ-037 Bench scenario: FIFO full, pop and issue in the same cycle -> occ stays 4, no overflow, order preserved.
REQ-038 Bench scenario: 64 back-to-back reads with resp_ready=1 -> 64 responses in order, one per cycle.
REQ-039 Bench scenario: RST_N pulsed low 1 cycle after 2 read fires -> resp_valid stays 0 until a new read; first post-reset response carries the new read's data.
REQ-040 Bench scenario: random valid/ready against a reference memory model -> all read data matches, and the overflow assertion never fires.
